// File: rtl/fec_pkg.sv
// Shared types and sizing constants for the downlink transmit scheduler.
package fec_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_GAP       = 3'd4
  } dl_sched_state_t;

  localparam int DL_SCHED_NUM_REQ   = 4;
  localparam int DL_SCHED_GAP_WIDTH = 8;
  localparam int DL_MSG_TAG_WIDTH   = 4;
  localparam int DL_MSG_LEN_WIDTH   = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches from i_ptr+1 upward, wrapping,
// and returns the first asserted request as a one-hot grant.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic [N-1:0]         o_grant,
  output logic                 o_valid
);

  localparam int PW = $clog2(N);

  always_comb begin : search
    logic [PW-1:0] w_idx;
    o_grant = '0;
    o_valid = 1'b0;
    w_idx   = '0;
    for (int i = 1; i <= N; i++) begin
      w_idx = PW'((32'(i_ptr) + i) % N);
      if (!o_valid && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        o_valid        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dl_tx_scheduler.sv
// Round-robin scheduler sharing one downlink controller among NUM_REQ requesters.
// Define DL_SCHED_TIMEOUT_EN to add a WAIT_BUSY/WAIT_DONE watchdog (timeout_err).
module dl_tx_scheduler
  import fec_pkg::*;
#(
  parameter int NUM_REQ       = DL_SCHED_NUM_REQ,
  parameter int GAP_WIDTH     = DL_SCHED_GAP_WIDTH,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    i_sched_en,
  input  logic [NUM_REQ-1:0]                      i_req,
  input  logic [NUM_REQ-1:0]                      i_req_enc_used,
  input  logic [NUM_REQ-1:0][DL_MSG_LEN_WIDTH-1:0] i_req_msg_len,
  input  logic [GAP_WIDTH-1:0]                    i_gap_cycles,
  input  logic [TIMEOUT_WIDTH-1:0]                i_timeout_limit,
  input  logic                                    i_dl_done,
  output logic                                    o_dl_start,
  output logic                                    o_enc_used,
  output logic [DL_MSG_LEN_WIDTH-1:0]             o_msg_len,
  output logic [DL_MSG_TAG_WIDTH-1:0]             o_msg_tag,
  output logic [NUM_REQ-1:0]                      o_grant,
  output logic [NUM_REQ-1:0]                      o_ack,
  output logic                                    o_busy,
  output logic                                    o_timeout_err
);

  localparam int PW = $clog2(NUM_REQ);

  dl_sched_state_t               r_state, w_next;
  logic [PW-1:0]                 r_ptr, r_win, w_arb_idx;
  logic [NUM_REQ-1:0]            r_grant, w_arb_gnt;
  logic                          w_arb_vld, r_enc;
  logic [DL_MSG_LEN_WIDTH-1:0]   r_len;
  logic [DL_MSG_TAG_WIDTH-1:0]   r_tag;
  logic [GAP_WIDTH-1:0]          r_gap;
  logic                          w_grant_go, w_done_ok, w_to, w_fin;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .i_req   (i_req),
    .i_ptr   (r_ptr),
    .o_grant (w_arb_gnt),
    .o_valid (w_arb_vld)
  );

  always_comb begin
    w_arb_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (w_arb_gnt[i]) w_arb_idx = PW'(i);
  end

  assign w_grant_go = (r_state == S_IDLE) && i_sched_en && w_arb_vld && i_dl_done;
  assign w_done_ok  = (r_state == S_WAIT_DONE) && i_dl_done;
  assign w_fin      = w_done_ok | w_to;

`ifdef DL_SCHED_TIMEOUT_EN
  // Counter reads k in the k-th cycle after START, so expiry lands exactly limit cycles after START.
  logic [TIMEOUT_WIDTH-1:0] r_wd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        r_wd <= '0;
    else if (r_state == S_START)    r_wd <= TIMEOUT_WIDTH'(1);
    else if (r_state == S_WAIT_BUSY || r_state == S_WAIT_DONE)
                                    r_wd <= r_wd + 1'b1;
  end

  assign w_to = (r_state == S_WAIT_BUSY || (r_state == S_WAIT_DONE && !i_dl_done)) &&
                (i_timeout_limit != '0) && (r_wd == i_timeout_limit);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^i_timeout_limit;
  assign w_to             = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    o_dl_start    = (r_state == S_START);
    o_busy        = (r_state != S_IDLE);
    o_ack         = w_fin ? r_grant : '0;
    o_timeout_err = w_to;
    unique case (r_state)
      S_IDLE:      if (w_grant_go) w_next = S_START;
      S_START:     w_next = S_WAIT_BUSY;
      S_WAIT_BUSY: if (!i_dl_done) w_next = S_WAIT_DONE;
      S_WAIT_DONE: w_next = S_WAIT_DONE;
      S_GAP:       if (r_gap == '0) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
    if (w_fin) w_next = (i_gap_cycles != '0) ? S_GAP : S_IDLE;
  end

  // Frame attributes are captured once at grant and held until the next grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr   <= PW'(NUM_REQ - 1);
      r_win   <= '0;
      r_grant <= '0;
      r_enc   <= 1'b0;
      r_len   <= '0;
      r_tag   <= '0;
      r_gap   <= '0;
    end else begin
      if (w_grant_go) begin
        r_win   <= w_arb_idx;
        r_grant <= w_arb_gnt;
        r_enc   <= i_req_enc_used[w_arb_idx];
        r_len   <= i_req_msg_len[w_arb_idx];
      end
      if (w_fin) begin
        r_grant <= '0;
        r_ptr   <= r_win;
        r_gap   <= i_gap_cycles - 1'b1;
        if (!w_to) r_tag <= r_tag + 1'b1;
      end else if (r_state == S_GAP && r_gap != '0) begin
        r_gap <= r_gap - 1'b1;
      end
    end
  end

  assign o_grant    = r_grant;
  assign o_enc_used = r_enc;
  assign o_msg_len  = r_len;
  assign o_msg_tag  = r_tag;

endmodule

// File: tb/tb_dl_tx_scheduler.sv
// Scoreboard bench for dl_tx_scheduler: driver/downlink model push expectations, negedge monitor checks.
module tb_dl_tx_scheduler;

  localparam int N  = 4;
  localparam int GW = 8;
  localparam int TW = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 i_sched_en = 1'b0;
  logic [N-1:0]         i_req = '0;
  logic [N-1:0]         i_req_enc_used = '0;
  logic [N-1:0][7:0]    i_req_msg_len = '0;
  logic [GW-1:0]        i_gap_cycles = '0;
  logic [TW-1:0]        i_timeout_limit = '0;
  logic                 i_dl_done = 1'b1;
  logic                 o_dl_start, o_enc_used, o_busy, o_timeout_err;
  logic [7:0]           o_msg_len;
  logic [3:0]           o_msg_tag;
  logic [N-1:0]         o_grant, o_ack;

  dl_tx_scheduler #(.NUM_REQ(N), .GAP_WIDTH(GW), .TIMEOUT_WIDTH(TW)) dut (
    .clk(clk), .rst(rst), .i_sched_en(i_sched_en), .i_req(i_req),
    .i_req_enc_used(i_req_enc_used), .i_req_msg_len(i_req_msg_len),
    .i_gap_cycles(i_gap_cycles), .i_timeout_limit(i_timeout_limit), .i_dl_done(i_dl_done),
    .o_dl_start(o_dl_start), .o_enc_used(o_enc_used), .o_msg_len(o_msg_len),
    .o_msg_tag(o_msg_tag), .o_grant(o_grant), .o_ack(o_ack), .o_busy(o_busy),
    .o_timeout_err(o_timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0, failures = 0;

  typedef struct { logic [N-1:0] oh; logic enc; logic [7:0] len; logic [3:0] tag; int cyc; } st_exp_t;
  typedef struct { logic [N-1:0] oh; logic enc; logic [7:0] len; logic [3:0] tag; int cyc; logic to; } ack_exp_t;
  st_exp_t  sq[$];
  ack_exp_t aq[$];

  // Reference model: pending set, per-requester payload, RR pointer, tag.
  logic [N-1:0] pend = '0;
  logic [N-1:0] m_enc = '0;
  logic [7:0]   m_len [N];
  int           ptr = N - 1, tag = 0, win = 0;
  logic [N-1:0] cur_oh;
  logic         cur_enc;
  logic [7:0]   cur_len;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick();
    for (int i = 1; i <= N; i++) begin
      int k = (ptr + i) % N;
      if (pend[k]) return k;
    end
    return -1;
  endfunction

  task automatic new_data(input int i);
    m_enc[i] = 1'($urandom);
    m_len[i] = 8'($urandom_range(1, 255));
  endtask

  task automatic drive_req();
    i_req = pend;
    for (int i = 0; i < N; i++) begin
      i_req_enc_used[i] = m_enc[i];
      i_req_msg_len[i]  = m_len[i];
    end
  endtask

  task automatic push_start(input int at);
    st_exp_t e;
    logic [N-1:0] one = 1;
    win     = rr_pick();
    cur_oh  = one << win;
    cur_enc = m_enc[win];
    cur_len = m_len[win];
    e.oh = cur_oh; e.enc = cur_enc; e.len = cur_len; e.tag = 4'(tag); e.cyc = at;
    sq.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_start(output bit ok);
    ok = 0;
    for (int t = 0; t < 60; t++) begin
      if (o_dl_start) begin ok = 1; return; end
      tick();
    end
    chk("start_wait_expired", 0, 1);
  endtask

  // Downlink model for one frame; returns in the ack cycle (or the cycle after a timeout ack).
  task automatic do_frame(input bit stuck, input bit drop_en);
    bit ok;
    int d, l;
    ack_exp_t a;
    wait_start(ok);
    if (!ok) return;
    if (drop_en) i_sched_en = 0;
    d = $urandom_range(1, 3);
    repeat (d) tick();
    i_dl_done = 0;
    for (int i = 0; i < N; i++)
      if (!(pend[i] && i != win)) new_data(i);
    drive_req();
    if (stuck) begin
`ifdef DL_SCHED_TIMEOUT_EN
      repeat (50 - d) tick();
      a.oh = cur_oh; a.enc = cur_enc; a.len = cur_len; a.tag = 4'(tag); a.cyc = cyc; a.to = 1;
      aq.push_back(a);
      ptr = win; pend[win] = 0; drive_req();
      tick();
      i_dl_done = 1;
      return;
`else
      repeat (60) tick();
      chk("stuck_busy", o_busy, 1);
      chk("stuck_no_timeout_err", o_timeout_err, 0);
`endif
    end
    l = $urandom_range(1, 8);
    repeat (l) tick();
    i_dl_done = 1;
    a.oh = cur_oh; a.enc = cur_enc; a.len = cur_len; a.tag = 4'(tag); a.cyc = cyc; a.to = 0;
    aq.push_back(a);
    ptr = win; tag = (tag + 1) % 16; pend[win] = 0;
    drive_req();
  endtask

  always @(negedge clk) begin : mon
    st_exp_t  e;
    ack_exp_t a;
    if (!rst) begin
      if (o_dl_start) begin
        if (sq.size() == 0) chk("unexpected_start", 1, 0);
        else begin
          e = sq.pop_front();
          chk("start_grant", o_grant, e.oh);
          chk("start_enc", o_enc_used, e.enc);
          chk("start_len", o_msg_len, e.len);
          chk("start_tag", o_msg_tag, e.tag);
          chk("start_cycle", cyc, e.cyc);
          chk("start_busy", o_busy, 1);
        end
      end
      if (o_ack != '0 || o_timeout_err) begin
        if (aq.size() == 0) chk("unexpected_ack", 1, 0);
        else begin
          a = aq.pop_front();
          chk("ack_onehot", o_ack, a.oh);
          chk("ack_grant_held", o_grant, a.oh);
          chk("ack_enc", o_enc_used, a.enc);
          chk("ack_len", o_msg_len, a.len);
          chk("ack_tag", o_msg_tag, a.tag);
          chk("ack_cycle", cyc, a.cyc);
          chk("ack_timeout_err", o_timeout_err, a.to);
        end
      end
    end
  end

  initial begin
    bit ok;
    for (int i = 0; i < N; i++) m_len[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", o_grant, 0);
    chk("rst_ack", o_ack, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_dl_start", o_dl_start, 0);
    chk("rst_tag", o_msg_tag, 0);
    chk("rst_len", o_msg_len, 0);
    chk("rst_enc", o_enc_used, 0);
    chk("rst_timeout_err", o_timeout_err, 0);
    rst = 0;
    tick();

    // Single requester, fixed payload
    pend = 4'b0001; m_enc[0] = 1; m_len[0] = 8'd20; drive_req();
    i_sched_en = 1;
    push_start(cyc + 1);
    do_frame(0, 0);

    // Random traffic and gaps; more than 16 frames so the tag wraps
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1) begin pend[i] = 1; new_data(i); end
      if (pend == '0) begin
        int b = $urandom_range(0, N - 1);
        pend[b] = 1; new_data(b);
      end
      drive_req();
      i_gap_cycles = GW'($urandom_range(0, 4));
      push_start(cyc + int'(i_gap_cycles) + 2);
      do_frame(0, 0);
    end

    // All requesters continuously asserted, gap 3
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i]) begin pend[i] = 1; new_data(i); end
      drive_req();
      i_gap_cycles = 3;
      push_start(cyc + 5);
      do_frame(0, 0);
    end
    pend = '0; drive_req();
    tick();

    // Downlink busy elsewhere while idle: no grant
    i_dl_done = 0;
    repeat (6) tick();
    pend[1] = 1; new_data(1); drive_req();
    repeat (5) tick();
    chk("idle_dlbusy_busy", o_busy, 0);
    chk("idle_dlbusy_grant", o_grant, 0);
    i_dl_done = 1;
    push_start(cyc + 1);
    do_frame(0, 1);

    // sched_en dropped mid-frame: frame acked, then hold until re-enabled
    pend[2] = 1; new_data(2); drive_req();
    repeat (8) tick();
    chk("hold_busy", o_busy, 0);
    chk("hold_grant", o_grant, 0);
    i_sched_en = 1;
    push_start(cyc + 1);
    do_frame(0, 0);

    // Reset during WAIT_DONE
    pend = 4'b0110; new_data(1); new_data(2); drive_req();
    i_gap_cycles = 0;
    push_start(cyc + 2);
    wait_start(ok);
    tick();
    i_dl_done = 0;
    repeat (3) tick();
    rst = 1;
    #1;
    chk("rstmid_grant", o_grant, 0);
    chk("rstmid_busy", o_busy, 0);
    chk("rstmid_tag", o_msg_tag, 0);
    chk("rstmid_ack", o_ack, 0);
    chk("rstmid_dl_start", o_dl_start, 0);
    ptr = N - 1; tag = 0;
    i_dl_done = 1;
    tick();
    rst = 0;
    pend = 4'b0101; new_data(0); new_data(2); drive_req();
    push_start(cyc + 1);
    do_frame(0, 0);

    // Downlink stuck low
    pend = 4'b1000; new_data(3); drive_req();
    i_gap_cycles = 2;
    i_timeout_limit = 50;
    push_start(cyc + 4);
    do_frame(1, 0);
    pend = '0; drive_req();
    repeat (10) tick();
    chk("final_tag", o_msg_tag, 4'(tag));
    chk("final_busy", o_busy, 0);
    chk("start_queue_drained", sq.size(), 0);
    chk("ack_queue_drained", aq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL global_timeout: got still running expected finished (cycle %0d)", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
